// File: rtl/mux2to2_arbiter_if.sv
// Handshake and routing bundle between two requesters, two consumers and the
// 2-to-2 round-robin arbiter.
interface mux2to2_arbiter_if #(
  parameter int unsigned N = 8
);
  logic         req1, dst1, ack1;
  logic         req2, dst2, ack2;
  logic [N-1:0] in1, in2;
  logic [N-1:0] out1, out2;
  logic         vld1, vld2;
  logic         rdy1, rdy2;
  logic [1:0]   select;
  logic         busy, drop;

  modport slave (
    input  req1, dst1, in1, req2, dst2, in2, rdy1, rdy2,
    output ack1, ack2, out1, out2, vld1, vld2, select, busy, drop
  );

  modport master (
    output req1, dst1, in1, req2, dst2, in2, rdy1, rdy2,
    input  ack1, ack2, out1, out2, vld1, vld2, select, busy, drop
  );
endinterface

// File: rtl/mux2to2_arbiter.sv
// Round-robin arbiter sharing a 2-to-2 byte route; one transfer held at a time,
// dropped if the selected consumer stalls for TIMEOUT cycles.
module mux2to2_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst_n,
  mux2to2_arbiter_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic         prio;
  logic [7:0]   wait_cnt;
  logic         elig1, elig2, win2, rdy_sel;
  logic         done, timeout, decide, grant;
  logic         dst_w;
  logic [N-1:0] data_w;

  always_comb begin
    elig1   = bus.req1 & ~bus.ack1;
    elig2   = bus.req2 & ~bus.ack2;
    win2    = elig2 & (~elig1 | prio);
    dst_w   = win2 ? bus.dst2 : bus.dst1;
    data_w  = win2 ? bus.in2 : bus.in1;
    // select doubles as the latched {src, dst} of the held transfer
    rdy_sel = bus.select[0] ? bus.rdy2 : bus.rdy1;
    done    = (state == SEND) & rdy_sel;
    timeout = (state == SEND) & ~rdy_sel & (wait_cnt == TO_LAST);
    decide  = (state == IDLE) | done | timeout;
    grant   = decide & (elig1 | elig2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      wait_cnt   <= '0;
      bus.select <= '0;
      bus.ack1   <= 1'b0;
      bus.ack2   <= 1'b0;
      bus.vld1   <= 1'b0;
      bus.vld2   <= 1'b0;
      bus.out1   <= '0;
      bus.out2   <= '0;
      bus.busy   <= 1'b0;
      bus.drop   <= 1'b0;
    end else begin
      bus.ack1 <= 1'b0;
      bus.ack2 <= 1'b0;
      bus.drop <= timeout;
      if (grant) begin
        state      <= SEND;
        prio       <= ~win2;
        wait_cnt   <= '0;
        bus.select <= {win2, dst_w};
        bus.ack1   <= ~win2;
        bus.ack2   <= win2;
        bus.vld1   <= ~dst_w;
        bus.vld2   <= dst_w;
        bus.out1   <= dst_w ? '0 : data_w;
        bus.out2   <= dst_w ? data_w : '0;
        bus.busy   <= 1'b1;
      end else if (decide) begin
        state    <= IDLE;
        bus.vld1 <= 1'b0;
        bus.vld2 <= 1'b0;
        bus.out1 <= '0;
        bus.out2 <= '0;
        bus.busy <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux2to2_arbiter.sv
// Scoreboard bench for mux2to2_arbiter: expected transfers are queued in
// grant order and matched against completions and drops seen on the outputs.
module tb_mux2to2_arbiter;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux2to2_arbiter_if #(.N(N)) bus ();
  mux2to2_arbiter #(.N(N), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       src;
    logic       dst;
    logic [7:0] data;
    logic       dropped;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic s, input logic d, input logic [7:0] v, input logic dr);
    exp_t e;
    e.src = s; e.dst = d; e.data = v; e.dropped = dr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ((bus.vld1 && bus.rdy1) || (bus.vld2 && bus.rdy2) || bus.drop)) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        if (bus.drop) begin
          check("sb_dropflag", {31'd0, e.dropped}, 1);
        end else begin
          check("sb_dropflag", {31'd0, e.dropped}, 0);
          check("sb_sel", {30'd0, bus.select}, {30'd0, e.src, e.dst});
          check("sb_data", e.dst ? bus.out2 : bus.out1, {24'd0, e.data});
          check("sb_other", e.dst ? {bus.vld1, bus.out1} : {bus.vld2, bus.out2}, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req1 = 1'b0; bus.dst1 = 1'b0; bus.in1 = '0; bus.rdy1 = 1'b0;
    bus.req2 = 1'b0; bus.dst2 = 1'b0; bus.in2 = '0; bus.rdy2 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present a word and hold it until ack is seen at an edge.
  task automatic send(input int k, input logic [7:0] d, input logic ds, input bit release_req);
    bit seen = 1'b0;
    if (k == 1) begin bus.req1 = 1'b1; bus.in1 = d; bus.dst1 = ds; end
    else        begin bus.req2 = 1'b1; bus.in2 = d; bus.dst2 = ds; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (k == 1) ? bus.ack1 : bus.ack2;
    end
    check($sformatf("ack%0d_seen", k), {31'd0, seen}, 1);
    tick();
    if (release_req) begin
      if (k == 1) bus.req1 = 1'b0;
      else        bus.req2 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, last;
    logic [7:0] words [4];

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_ctl", {24'd0, bus.ack1, bus.ack2, bus.vld1, bus.vld2, bus.busy, bus.drop, bus.select}, 0);
    check("rst_out", {16'd0, bus.out1, bus.out2}, 0);

    // single transfer, minimum latency
    tick();
    bus.req1 = 1'b1; bus.dst1 = 1'b0; bus.in1 = 8'd200; bus.rdy1 = 1'b1;
    push(1'b0, 1'b0, 8'd200, 1'b0);
    tick();
    @(negedge clk);
    check("t1_ack1", {31'd0, bus.ack1}, 1);
    check("t1_sel", {30'd0, bus.select}, 0);
    check("t1_out1", {24'd0, bus.out1}, 200);
    check("t1_vld1", {31'd0, bus.vld1}, 1);
    check("t1_out2", {24'd0, bus.out2}, 0);
    tick();
    bus.req1 = 1'b0;
    @(negedge clk);
    check("t1_vld1_after", {31'd0, bus.vld1}, 0);
    check("t1_busy_after", {31'd0, bus.busy}, 0);

    // simultaneous requests, back-to-back, then priority alternation
    do_reset();
    bus.rdy1 = 1'b1; bus.rdy2 = 1'b1;
    push(1'b0, 1'b1, 8'd200, 1'b0);
    push(1'b1, 1'b0, 8'd100, 1'b0);
    fork
      begin send(1, 8'd200, 1'b1, 1'b1); t1 = cyc; end
      begin send(2, 8'd100, 1'b0, 1'b1); t2 = cyc; end
    join
    check("t2_b2b", t2 - t1, 1);
    push(1'b0, 1'b0, 8'd33, 1'b0);
    send(1, 8'd33, 1'b0, 1'b1);
    push(1'b1, 1'b0, 8'd44, 1'b0);
    push(1'b0, 1'b1, 8'd55, 1'b0);
    fork
      send(1, 8'd55, 1'b1, 1'b1);
      send(2, 8'd44, 1'b0, 1'b1);
    join
    tick();

    // stalled consumer completes on the edge where wait_cnt hits TIMEOUT-1
    do_reset();
    push(1'b1, 1'b1, 8'd100, 1'b0);
    bus.req2 = 1'b1; bus.dst2 = 1'b1; bus.in2 = 8'd100;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_vld2", {31'd0, bus.vld2}, 1);
      check("t3_out2", {24'd0, bus.out2}, 100);
      check("t3_sel", {30'd0, bus.select}, 3);
      check("t3_drop", {31'd0, bus.drop}, 0);
      tick();
      if (i == 0) bus.req2 = 1'b0;
      if (i == 2) bus.rdy2 = 1'b1;
    end
    @(negedge clk);
    check("t3_end", {29'd0, bus.vld2, bus.drop, bus.busy}, 0);

    // timeout drop
    do_reset();
    push(1'b0, 1'b0, 8'd55, 1'b1);
    bus.req1 = 1'b1; bus.dst1 = 1'b0; bus.in1 = 8'd55;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_vld1", {31'd0, bus.vld1}, 1);
      check("t4_nodrop", {31'd0, bus.drop}, 0);
      tick();
      if (i == 0) bus.req1 = 1'b0;
    end
    @(negedge clk);
    check("t4_drop", {31'd0, bus.drop}, 1);
    check("t4_vld1_low", {23'd0, bus.vld1, bus.out1}, 0);
    tick();
    @(negedge clk);
    check("t4_idle", {30'd0, bus.drop, bus.busy}, 0);

    // asynchronous reset mid-transfer
    do_reset();
    bus.req2 = 1'b1; bus.dst2 = 1'b1; bus.in2 = 8'd77;
    tick();
    @(negedge clk);
    check("t5_vld2", {31'd0, bus.vld2}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {24'd0, bus.ack1, bus.ack2, bus.vld1, bus.vld2, bus.busy, bus.drop, bus.select}, 0);
    check("t5_rst_out", {16'd0, bus.out1, bus.out2}, 0);
    bus.rdy1 = 1'b1; bus.rdy2 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(1'b0, 1'b0, 8'd11, 1'b0);
    push(1'b1, 1'b1, 8'd77, 1'b0);
    fork
      send(1, 8'd11, 1'b0, 1'b1);
      send(2, 8'd77, 1'b1, 1'b1);
    join
    tick();

    // single requester streaming: one ack every second cycle
    do_reset();
    bus.rdy1 = 1'b1;
    words[0] = 8'd10; words[1] = 8'd20; words[2] = 8'd30; words[3] = 8'd40;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b0, words[i], 1'b0);
      send(1, words[i], 1'b0, i == 3);
      if (i > 0) check("t6_ack_gap", cyc - last, 2);
      last = cyc;
    end
    repeat (3) tick();

    check("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
